// File: rtl/grid_ctrl_pkg.sv
// rtl/grid_ctrl_pkg.sv - shared state encoding and default sizes for the grid run controller
package grid_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } run_state_e;

    localparam int DEF_NUM_AGENTS = 64;
    localparam int DEF_STEP_W     = 16;
    localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush; a push on full is taken only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, rd_ptr_q;
    logic             wr_en, rd_en;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign wr_en    = push && (!full || pop);
    assign rd_en    = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/grid_run_ctrl.sv
// rtl/grid_run_ctrl.sv - loads an initial pattern into the agent grid, runs it for N steps
// and streams {step, infected count} samples through a small FIFO.
module grid_run_ctrl
    import grid_ctrl_pkg::*;
#(
    parameter int NUM_AGENTS = DEF_NUM_AGENTS,
    parameter int STEP_W     = DEF_STEP_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = $clog2(NUM_AGENTS + 1),
    parameter int ADDR_W     = (NUM_AGENTS > 32) ? $clog2(NUM_AGENTS / 32) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_wr,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [31:0]           cfg_data,
    input  logic                  start,
    input  logic                  abort,
    input  logic [STEP_W-1:0]     num_steps,
    output logic                  load_state,
    output logic [NUM_AGENTS-1:0] init_state,
    input  logic [NUM_AGENTS-1:0] curr_state,
    output logic                  smp_valid,
    input  logic                  smp_ready,
    output logic [STEP_W-1:0]     smp_step,
    output logic [CNT_W-1:0]      smp_count,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);
    localparam int WORDS = NUM_AGENTS / 32;
    localparam int FW    = STEP_W + CNT_W;

    run_state_e            state_q, state_d;
    logic                  armed_q;
    logic [NUM_AGENTS-1:0] pattern_q;
    logic [STEP_W-1:0]     nsteps_q, nsteps_d, step_q, step_d;
    logic                  s1_vld_q, s2_vld_q;
    logic [NUM_AGENTS-1:0] s1_data_q;
    logic [STEP_W-1:0]     s1_step_q, s2_step_q;
    logic [CNT_W-1:0]      s2_count_q, pop_cnt;
    logic                  overrun_q, overrun_d;
    logic                  start_ok, run_smp, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FW-1:0]         fifo_rdata;

    // armed_q holds off start for the first edge after reset release
    assign start_ok   = start && armed_q && !abort && (state_q == ST_IDLE);
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign load_state = (state_q == ST_LOAD) && !abort;
    assign done       = (state_q == ST_DONE) && !abort;
    assign init_state = pattern_q;
    assign overrun    = overrun_q;
    assign smp_valid  = !fifo_empty;
    assign fifo_pop   = smp_valid && smp_ready;
    assign fifo_push  = s2_vld_q && !abort;
    assign {smp_step, smp_count} = fifo_rdata;

    always_comb begin
        state_d  = state_q;
        nsteps_d = nsteps_q;
        step_d   = step_q;
        run_smp  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    if (num_steps == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_LOAD;
                        nsteps_d = num_steps;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
                step_d  = '0;
            end
            ST_RUN: begin
                run_smp = 1'b1;
                step_d  = step_q + STEP_W'(1);
                if (step_q == nsteps_q - STEP_W'(1)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!s1_vld_q && !s2_vld_q && fifo_empty) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    always_comb begin
        overrun_d = overrun_q;
        if (start_ok) overrun_d = 1'b0;
        else if (fifo_push && fifo_full && !fifo_pop) overrun_d = 1'b1;
    end

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < NUM_AGENTS; i++) pop_cnt = pop_cnt + CNT_W'(s1_data_q[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            armed_q   <= 1'b0;
            nsteps_q  <= '0;
            step_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= 1'b1;
            nsteps_q  <= nsteps_d;
            step_q    <= step_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= '0;
        end else if (cfg_wr && !busy) begin
            for (int w = 0; w < WORDS; w++) begin
                if (cfg_addr == ADDR_W'(w)) pattern_q[w*32 +: 32] <= cfg_data;
            end
        end
    end

    // Sample register then count register: push lands two cycles after its RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s1_data_q  <= '0;
            s1_step_q  <= '0;
            s2_step_q  <= '0;
            s2_count_q <= '0;
        end else begin
            s1_vld_q   <= run_smp && !abort;
            s2_vld_q   <= s1_vld_q && !abort;
            s1_data_q  <= curr_state;
            s1_step_q  <= step_q;
            s2_step_q  <= s1_step_q;
            s2_count_q <= pop_cnt;
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .push      (fifo_push),
        .push_data ({s2_step_q, s2_count_q}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_grid_run_ctrl.sv
// tb/tb_grid_run_ctrl.sv - self-checking bench for grid_run_ctrl with a spreading-infection grid model
module tb_grid_run_ctrl;
    localparam int N     = 64;
    localparam int SW    = 6;
    localparam int CW    = 7;

    typedef struct packed {
        logic [SW-1:0] step;
        logic [CW-1:0] count;
    } smp_t;

    typedef struct {
        logic [63:0] pattern;
        int          steps;
        int          exp_samples;
        int          exp_last_step;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_wr;
    logic [0:0]    cfg_addr;
    logic [31:0]   cfg_data;
    logic          start, abort;
    logic [SW-1:0] num_steps;
    logic          load_state;
    logic [N-1:0]  init_state;
    logic [N-1:0]  curr_state;
    logic          smp_valid, smp_ready;
    logic [SW-1:0] smp_step;
    logic [CW-1:0] smp_count;
    logic          busy, done, overrun;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   load_cnt = 0, done_cnt = 0, smp_cnt = 0;
    int   load_cyc = 0, last_step = -1;
    bit   first_pending = 0;
    smp_t exp_q[$];
    logic [N-1:0] grid_q = '0;
    vec_t vecs[5];

    grid_run_ctrl #(
        .NUM_AGENTS (N),
        .STEP_W     (SW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .start      (start),
        .abort      (abort),
        .num_steps  (num_steps),
        .load_state (load_state),
        .init_state (init_state),
        .curr_state (curr_state),
        .smp_valid  (smp_valid),
        .smp_ready  (smp_ready),
        .smp_step   (smp_step),
        .smp_count  (smp_count),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Grid model: each step every infected agent infects its upper neighbour
    always @(posedge clk) begin
        if (load_state) grid_q <= init_state;
        else            grid_q <= grid_q | (grid_q << 1);
    end
    assign curr_state = grid_q;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (load_state) begin
                load_cnt++;
                load_cyc      = cyc;
                first_pending = 1;
            end
            if (done) done_cnt++;
            if (smp_valid && first_pending) begin
                check("first_valid_latency", 64'(cyc - load_cyc), 64'd4);
                first_pending = 0;
            end
            if (smp_valid && smp_ready) begin
                smp_cnt++;
                last_step = int'(smp_step);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_sample actual step=%0d count=%0d required none", smp_step, smp_count);
                end else begin
                    smp_t e;
                    e = exp_q.pop_front();
                    check("sample_step_count", 64'({smp_step, smp_count}), 64'({e.step, e.count}));
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write_pattern(input logic [63:0] p);
        cfg_wr = 1'b1; cfg_addr = 1'b0; cfg_data = p[31:0];
        cycle();
        cfg_addr = 1'b1; cfg_data = p[63:32];
        cycle();
        cfg_wr = 1'b0;
    endtask

    task automatic push_expected(input logic [63:0] pattern, input int n);
        logic [63:0] p;
        p = pattern;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{step: SW'(k), count: CW'($countones(p))});
            p = p | (p << 1);
        end
    endtask

    task automatic wait_done(input int d0, input int bound);
        int n;
        n = 0;
        while (done_cnt == d0 && n < bound) begin
            cycle();
            n++;
        end
        check("done_within_bound", 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic pulse_start(input int steps);
        num_steps = SW'(steps);
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int l0, d0, s0;
        write_pattern(v.pattern);
        check("init_state", init_state, v.pattern);
        push_expected(v.pattern, v.exp_samples);
        l0 = load_cnt; d0 = done_cnt; s0 = smp_cnt;
        pulse_start(v.steps);
        wait_done(d0, v.steps + 20);
        cycle(); cycle();
        check("load_pulses", 64'(load_cnt - l0), 64'd1);
        check("sample_total", 64'(smp_cnt - s0), 64'(v.exp_samples));
        check("last_step", 64'(last_step), 64'(v.exp_last_step));
        check("done_pulses", 64'(done_cnt - d0), 64'd1);
        check("overrun_clear", 64'(overrun), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int l0, d0, s0;

        vecs[0] = '{64'h0000_0000_0000_0005, 3, 3, 2};
        vecs[1] = '{64'h8000_0000_0000_0000, 2, 2, 1};
        vecs[2] = '{64'h0000_0000_0000_0000, 5, 5, 4};
        vecs[3] = '{64'h0000_0000_FFFF_FFFF, 63, 63, 62};
        vecs[4] = '{64'h0001_0000_0000_0000, 1, 1, 0};

        rst_n = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; abort = 1'b0; num_steps = '0; smp_ready = 1'b1;
        #3;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_smp_valid", 64'(smp_valid), 64'd0);
        check("rst_load_state", 64'(load_state), 64'd0);
        check("rst_init_state", init_state, 64'd0);
        #10 rst_n = 1'b1;
        cycle(); cycle();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Back-pressure: only steps 0..3 fit, the rest are dropped
        write_pattern(64'h5);
        push_expected(64'h5, 4);
        smp_ready = 1'b0;
        d0 = done_cnt; s0 = smp_cnt;
        pulse_start(10);
        repeat (6) cycle();
        check("stall_head", 64'({smp_valid, smp_step, smp_count}), 64'({1'b1, 6'd0, 7'd2}));
        repeat (10) cycle();
        check("stall_head_stable", 64'({smp_valid, smp_step, smp_count}), 64'({1'b1, 6'd0, 7'd2}));
        check("stall_overrun", 64'(overrun), 64'd1);
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_no_done", 64'(done_cnt - d0), 64'd0);
        smp_ready = 1'b1;
        wait_done(d0, 30);
        cycle();
        check("stall_drained", 64'(smp_cnt - s0), 64'd4);
        check("overrun_sticky", 64'(overrun), 64'd1);
        run_vec(vecs[0]);

        // Zero-length run
        l0 = load_cnt; d0 = done_cnt; s0 = smp_cnt;
        pulse_start(0);
        check("zero_done_pulse", 64'(done), 64'd1);
        cycle();
        check("zero_done_low", 64'(done), 64'd0);
        cycle(); cycle();
        check("zero_no_load", 64'(load_cnt - l0), 64'd0);
        check("zero_no_samples", 64'(smp_cnt - s0), 64'd0);

        // Abort on the second RUN cycle
        write_pattern(64'hF);
        d0 = done_cnt; s0 = smp_cnt;
        pulse_start(8);
        cycle();
        cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("abort_idle", 64'({busy, smp_valid, load_state, done}), 64'd0);
        repeat (6) cycle();
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_no_samples", 64'(smp_cnt - s0), 64'd0);
        run_vec(vecs[1]);

        // cfg_wr and start during RUN are both ignored
        write_pattern(64'h00F0);
        push_expected(64'h00F0, 6);
        d0 = done_cnt; s0 = smp_cnt;
        pulse_start(6);
        cycle(); cycle();
        cfg_wr = 1'b1; cfg_addr = 1'b0; cfg_data = 32'hFFFF_FFFF;
        num_steps = 6'd2; start = 1'b1;
        cycle();
        cfg_wr = 1'b0; start = 1'b0;
        check("run_cfg_ignored", init_state, 64'h00F0);
        wait_done(d0, 30);
        cycle(); cycle();
        check("run_start_ignored", 64'(smp_cnt - s0), 64'd6);
        check("run_last_step", 64'(last_step), 64'd5);

        // Asynchronous reset in DRAIN with two words queued
        write_pattern(64'h3);
        push_expected(64'h3, 2);
        smp_ready = 1'b0;
        pulse_start(2);
        repeat (6) cycle();
        check("drain_pending", 64'({busy, smp_valid}), 64'b11);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outputs", 64'({busy, smp_valid, done, overrun, load_state}), 64'd0);
        check("async_rst_pattern", init_state, 64'd0);
        exp_q.delete();
        smp_ready = 1'b1;
        #10;
        rst_n = 1'b1;
        num_steps = 6'd1;
        start = 1'b1;
        push_expected(64'h0, 1);
        d0 = done_cnt; s0 = smp_cnt;
        cycle();
        check("first_edge_ignored", 64'(busy), 64'd0);
        cycle();
        start = 1'b0;
        check("second_edge_start", 64'({busy, load_state}), 64'b11);
        wait_done(d0, 20);
        cycle(); cycle();
        check("post_reset_samples", 64'(smp_cnt - s0), 64'd1);
        check("post_reset_scoreboard", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
